// File: rtl/serial_add_sequencer_if.sv
// serial_add_sequencer_if
// Groups the operand-side and result-side ready/valid handshakes of
// serial_add_sequencer.
//   slave  : used by the sequencer (consumes a/b, produces sum/carry_out)
//   master : used by the producer/consumer side (e.g. a testbench)
// Signals: in_valid, in_ready, a, b, out_valid, out_ready, sum, carry_out,
//          busy, and op_sub when SERIAL_ADD_SUB_EN is defined.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;
`ifdef SERIAL_ADD_SUB_EN
  logic             op_sub;

  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );
`else
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );
`endif
endinterface

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
// Bit-serial adder: loads a parallel operand pair, adds it LSB-first
// through a single full adder and carry flop over WIDTH cycles, then
// presents the parallel sum and final carry until the consumer takes it.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : serial_add_sequencer_if.slave (operand and result handshakes)
// Optional build macro SERIAL_ADD_SUB_EN adds op_sub on the interface:
//   op_sub=1 at load computes a-b (b inverted, carry seeded with 1);
//   carry_out=1 then means "no borrow".
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// SHIFT | one full-adder step per cycle, WIDTH cycles
// DONE  | result held with out_valid=1 until out_ready
module serial_add_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic                   clk,
  input logic                   reset_n,
  serial_add_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             out_valid_q;

  logic             sum_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

  assign sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_d   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the first sum bit.
  assign res_d     = {sum_bit_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_ADD_SUB_EN
  // a - b = a + ~b + 1: invert b and seed the carry with 1.
  assign b_load     = bus.op_sub ? ~bus.b : bus.b;
  assign carry_init = bus.op_sub;
`else
  assign b_load     = bus.b;
  assign carry_init = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= b_load;
            carry_q <= carry_init;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Publish straight from the final step so out_valid rises with DONE.
            sum_q       <= res_d;
            carry_out_q <= carry_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer
// Directed and random operations on an 8-bit serial_add_sequencer, compared
// against plain integer addition/subtraction. Inputs change and outputs
// are sampled on the falling edge.
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sub(input logic sub);
`ifdef SERIAL_ADD_SUB_EN
    bus.op_sub = sub;
`else
    if (sub) $display("note: subtraction requested without SERIAL_ADD_SUB_EN");
`endif
  endtask

  // Reference result {carry_out, sum} from integer arithmetic.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic sub);
    int unsigned r;
    if (sub) r = int'(a) + ((1 << WIDTH) - 1 - int'(b)) + 1;
    else     r = int'(a) + int'(b);
    return r[WIDTH:0];
  endfunction

  // Entered and left on a falling edge with the block in IDLE. The cycle of
  // the first falling edge is the handshake cycle (cycle 0).
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                       input int stall);
    logic [WIDTH:0] exp;
    exp = model(a, b, sub);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    drive_sub(sub);
    check("in_ready_c0", bus.in_ready, 1'b1);
    @(negedge clk);
    for (int c = 1; c <= WIDTH; c++) begin
      check("busy_shift", bus.busy, 1'b1);
      check("in_ready_shift", bus.in_ready, 1'b0);
      check("out_valid_shift", bus.out_valid, 1'b0);
      // Noise while shifting must not disturb the operation.
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a         = WIDTH'($urandom);
      bus.b         = WIDTH'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      drive_sub(1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("out_valid_done", bus.out_valid, 1'b1);
    check("sum", bus.sum, exp[WIDTH-1:0]);
    check("carry_out", bus.carry_out, exp[WIDTH]);
    check("busy_done", bus.busy, 1'b1);
    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_sum", bus.sum, exp[WIDTH-1:0]);
      check("stall_carry", bus.carry_out, exp[WIDTH]);
      check("stall_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("idle_out_valid", bus.out_valid, 1'b0);
    check("idle_in_ready", bus.in_ready, 1'b1);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_sum_hold", bus.sum, exp[WIDTH-1:0]);
    check("idle_carry_hold", bus.carry_out, exp[WIDTH]);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'hFF;
    bus.b         = 8'hFF;
    bus.out_ready = 1'b0;
    drive_sub(1'b0);
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    @(negedge clk);
    check("rst_sum", bus.sum, 8'h00);
    check("rst_carry", bus.carry_out, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy2", bus.busy, 1'b0);

    do_op(8'h5A, 8'h33, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b0, 0);
    do_op(8'h80, 8'h80, 1'b0, 5);
    do_op(8'h0F, 8'h01, 1'b0, 1);

    // Reset in cycle 4 of a SHIFT discards the operation.
    bus.a        = 8'hAA;
    bus.b        = 8'h55;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", bus.busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_sum", bus.sum, 8'h00);
    reset_n = 1'b1;
    do_op(8'h01, 8'h02, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b1, 0);
    do_op(8'h01, 8'h02, 1'b1, 2);
`endif

    for (int i = 0; i < 40; i++) begin
      logic sub;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      do_op(WIDTH'($urandom), WIDTH'($urandom), sub, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Controller and datapath for one bit-serial addition: accepts a parallel operand pair, shifts both operands LSB-first through a 1-bit full adder with a carry flip-flop for WIDTH cycles, and assembles the serial sum bits back into a parallel word.
- Sits between a parallel-operand producer and a result consumer.
- Ready/valid handshake on both sides.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  sum/carry_out valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  parallel result.
- carry_out  output  1  final carry out of the MSB.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n low at a clk edge):
  - FSM goes to IDLE.
  - Operand shift regs, result reg, carry FF and bit counter cleared.
  - sum=0, carry_out=0, out_valid=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - Inputs are ignored while reset_n is low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a/b into the operand regs, carry<=0, cnt<=0, go to SHIFT.
- SHIFT (in_ready=0):
  - Each cycle: s = a_reg[0]^b_reg[0]^carry; carry <= majority(a_reg[0],b_reg[0],carry).
  - Operand regs shift right by one.
  - Result reg shifts right with s inserted at the MSB.
  - cnt increments.
  - When cnt==WIDTH-1, that cycle's shift completes and FSM goes to DONE. Exactly WIDTH shift cycles.
- DONE:
  - out_valid=1; sum=result reg; carry_out=carry FF.
  - Both held stable until out_ready samples 1.
  - On out_valid&&out_ready: go to IDLE. sum and carry_out keep their last values until the next DONE.
- Latency: handshake in cycle 0 → SHIFT in cycles 1..WIDTH → out_valid first high in cycle WIDTH+1.
- Throughput: min WIDTH+2 cycles per operation (in_ready only in IDLE).
- Arithmetic: unsigned, modulo 2^WIDTH; overflow reported only via carry_out.
- in_valid outside IDLE: ignored; the producer must hold a/b until the handshake.
- a/b changing during SHIFT: no effect.
- out_ready high before out_valid: no effect.
- out_ready held low: the block stalls in DONE indefinitely, with no loss or corruption.
- Reset mid-SHIFT or in DONE: the partial/pending result is discarded and all outputs return to reset values on the next cycle.
- in_ready and busy are combinational decodes of the state register. All other outputs are registered.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), sampled at the input handshake.
  - If op_sub=1: b is inverted on load and carry initialises to 1, so the result is a−b modulo 2^WIDTH.
  - carry_out=1 means no borrow; carry_out=0 means borrow.
  - op_sub=0 behaves identically to addition.
- Undefined: no op_sub port; addition only; carry always initialises to 0.

Test Plan (WIDTH=8):
- a=0x5A, b=0x33, out_ready=1 → out_valid in cycle 9 after the handshake; sum=0x8D, carry_out=0; busy high in cycles 1..9.
- a=0xFF, b=0x01 → sum=0x00, carry_out=1. Then a=0x00, b=0x00 back-to-back → sum=0x00, carry_out=0; in_ready low for the whole 10-cycle window.
- a=0x80, b=0x80, out_ready held low 5 cycles after out_valid → sum=0x00 and carry_out=1 stable all 5 cycles; in_ready stays 0; IDLE entered the cycle after out_ready=1.
- Start a=0xAA, b=0x55; assert reset_n=0 in cycle 4 → next cycle out_valid=0, busy=0, in_ready=1, sum=0x00. A fresh a=0x01, b=0x02 afterwards → sum=0x03.
- in_valid pulsed with a=0x11 during SHIFT of op 0x0F+0x01 → ignored; sum=0x10.
- With SERIAL_ADD_SUB_EN and op_sub=1:
  - a=0x10, b=0x01 → sum=0x0F, carry_out=1.
  - a=0x01, b=0x02 → sum=0xFF, carry_out=0.
